// File: rtl/pq_pkg.sv
// Shared priority-queue payload sizing.
// Holds the default key/value field widths used by PQ masters and PQ
// implementations so every block agrees on the {key,val} entry layout.
package pq_pkg;

  localparam int unsigned KEY_WIDTH = 8;
  localparam int unsigned VAL_WIDTH = 8;
  localparam int unsigned ENTRY_W   = KEY_WIDTH + VAL_WIDTH;

  // One PQ entry as it appears on kvo.
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } pq_entry_t;

endpackage : pq_pkg

// File: rtl/pq_drain.sv
// pq_drain: dequeue master for a priority queue.
// Pulls entries off the PQ head (kvo/empty/deq) and forwards them as
// key/value beats on a valid/ready stream through a 2-entry skid FIFO.
// A drain either removes a fixed number of entries or runs continuously
// until stop.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   kvo, empty, deq    PQ head entry {key,val}, PQ empty, head removal
//   start, count, stop drain control (count=0 -> continuous)
//   m_valid, m_ready,  output stream
//   m_key, m_val
//   busy, done         drain in progress / one-cycle completion pulse
//   order_err          sticky priority-order violation
//
// Optional feature macro: PQ_DRAIN_CHECK_EN enables the in-order key
// checker; without it order_err is tied low and no checker is built.
module pq_drain #(
  parameter int unsigned KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int unsigned VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned MIN_FIRST = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
  input  logic                           empty,
  output logic                           deq,
  input  logic                           start,
  input  logic [COUNT_W-1:0]             count,
  input  logic                           stop,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [KEY_WIDTH-1:0]           m_key,
  output logic [VAL_WIDTH-1:0]           m_val,
  output logic                           busy,
  output logic                           done,
  output logic                           order_err
);

  localparam int unsigned KV_W  = KEY_WIDTH + VAL_WIDTH;
  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [COUNT_W-1:0] target_q;
  logic [COUNT_W-1:0] issued_q;
  logic [COUNT_W-1:0] issued_inc;
  logic               start_acc;
  logic               room;
  logic               below_target;

  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;
  logic [KV_W-1:0]    slot_q;
  logic               push;
  logic               pop;

  assign issued_inc   = issued_q + COUNT_W'(1);
  assign start_acc    = (state_q == IDLE) && start;
  // Occupancy before this cycle's pop, so the FIFO can never overflow.
  assign room         = (occ_q != OCC_W'(2));
  assign below_target = (target_q == '0) || (issued_q < target_q);

  // Next-state and deq decode
  always_comb begin
    state_d = state_q;
    deq     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = DRAIN;
      end
      DRAIN: begin
        deq = !empty && room && below_target;
        // A final deq coinciding with stop still completes; its entry is
        // flushed out before DONE.
        if (stop || (deq && (target_q != '0) && (issued_inc == target_q)))
          state_d = FLUSH;
      end
      FLUSH: begin
        if (occ_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      issued_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == DRAIN) || (state_d == FLUSH);
      done    <= (state_d == DONE);
      if (start_acc) begin
        target_q <= count;
        issued_q <= '0;
      end else if (deq && (issued_q != '1)) begin
        // Saturates in continuous mode rather than wrapping.
        issued_q <= issued_inc;
      end
    end
  end

  // Skid FIFO: head lives in m_key/m_val, slot_q holds the second entry.
  assign push = deq;
  assign pop  = m_valid && m_ready;

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      m_valid <= 1'b0;
      m_key   <= '0;
      m_val   <= '0;
      slot_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      m_valid <= (occ_d != '0);
      // Head loads from kvo when it is (or is about to become) the oldest
      // entry, otherwise it advances from the slot on a pop.
      if (push && ((occ_q == '0) || ((occ_q == OCC_W'(1)) && pop)))
        {m_key, m_val} <= kvo;
      else if (pop && (occ_q == OCC_W'(2)))
        {m_key, m_val} <= slot_q;
      if (push && (occ_q == OCC_W'(1)) && !pop)
        slot_q <= kvo;
    end
  end

`ifdef PQ_DRAIN_CHECK_EN
  logic [KEY_WIDTH-1:0] deq_key;
  logic [KEY_WIDTH-1:0] prev_key_q;
  logic                 have_prev_q;
  logic                 out_of_order;

  assign deq_key      = kvo[KV_W-1 -: KEY_WIDTH];
  // Equal keys are legal in either direction.
  assign out_of_order = (MIN_FIRST != 0) ? (deq_key < prev_key_q)
                                         : (deq_key > prev_key_q);

  // Order checker against the previous key of the same drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_key_q  <= '0;
      have_prev_q <= 1'b0;
      order_err   <= 1'b0;
    end else if (start_acc) begin
      have_prev_q <= 1'b0;
      order_err   <= 1'b0;
    end else if (deq) begin
      if (have_prev_q && out_of_order) order_err <= 1'b1;
      prev_key_q  <= deq_key;
      have_prev_q <= 1'b1;
    end
  end
`else
  logic unused_min_first;
  assign unused_min_first = (MIN_FIRST != 0);
  assign order_err        = 1'b0;
`endif

endmodule : pq_drain

// File: tb/tb_pq_drain.sv
// Self-checking bench for pq_drain: a behavioural sorted-queue PQ feeds the
// DUT, a scoreboard records each removed head, and an independent monitor
// compares every delivered beat against it.
module tb_pq_drain;

  localparam int unsigned KW = 8;
  localparam int unsigned VW = 8;
  localparam int unsigned CW = 8;
`ifdef PQ_DRAIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic [KW+VW-1:0] kvo;
  logic          empty;
  logic          deq;
  logic          start;
  logic [CW-1:0] count;
  logic          stop;
  logic          m_valid;
  logic          m_ready;
  logic [KW-1:0] m_key;
  logic [VW-1:0] m_val;
  logic          busy;
  logic          done;
  logic          order_err;

  pq_drain #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .COUNT_W(CW), .MIN_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .kvo(kvo), .empty(empty), .deq(deq),
    .start(start), .count(count), .stop(stop),
    .m_valid(m_valid), .m_ready(m_ready), .m_key(m_key), .m_val(m_val),
    .busy(busy), .done(done), .order_err(order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t pq[$];
  ent_t sb[$];
  ent_t enq_req[$];
  logic [KW-1:0] got_keys[$];
  logic [VW-1:0] got_vals[$];
  int   acc_cyc[$];

  int checks = 0;
  int failures = 0;
  int deq_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_deq_cyc = -1;
  int drain_target = 0;
  int drain_issued = 0;
  bit pend_pop = 1'b0;
  bit faulty = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural PQ: smallest key first (FIFO order when faulty is set).
  initial begin : pq_model
    ent_t e;
    int   pos;
    kvo   = '0;
    empty = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (pend_pop) begin
        if (pq.size() > 0) pq.delete(0);
        pend_pop = 1'b0;
      end
      while (enq_req.size() > 0) begin
        e = enq_req.pop_front();
        if (faulty) pq.push_back(e);
        else begin
          pos = pq.size();
          for (int i = pq.size() - 1; i >= 0; i--)
            if (e.key < pq[i].key) pos = i;
          pq.insert(pos, e);
        end
      end
      empty = (pq.size() == 0);
      kvo   = (pq.size() > 0) ? pq[0] : '0;
      #1;
      if (deq === 1'b1) begin
        check("deq_when_empty", 32'(empty), 0);
        check("deq_fifo_room", 32'(sb.size() < 2), 1);
        check("deq_while_busy", 32'(busy), 1);
        if (drain_target != 0) check("deq_within_count", 32'(drain_issued < drain_target), 1);
        if (pq.size() > 0) sb.push_back(pq[0]);
        pend_pop = 1'b1;
        deq_cnt++;
        drain_issued++;
        last_deq_cyc = cyc;
      end
    end
  end

  // Output monitor: compares beats with the scoreboard, tracks done pulses.
  initial begin : monitor
    ent_t e;
    int   occ;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        sb.delete();
      end else begin
        occ = sb.size() - (pend_pop ? 1 : 0);
        check("m_valid_occ", 32'(m_valid), 32'(occ != 0));
        if (m_valid && m_ready) begin
          if (sb.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            e = sb.pop_front();
            check("m_key", 32'(m_key), 32'(e.key));
            check("m_val", 32'(m_val), 32'(e.val));
            got_keys.push_back(m_key);
            got_vals.push_back(m_val);
            acc_cyc.push_back(cyc);
          end
        end
        if (done) begin
          done_cnt++;
          check("done_fifo_empty", 32'(sb.size()), 0);
          check("done_not_busy", 32'(busy), 0);
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic enq(input logic [KW-1:0] k, input logic [VW-1:0] v);
    enq_req.push_back(ent_t'({k, v}));
  endtask

  task automatic do_start(input int c);
    bit acc;
    tick();
    acc   = !busy;
    start = 1'b1;
    count = CW'(c);
    if (acc) begin
      drain_target = c;
      drain_issued = 0;
    end
    tick();
    start = 1'b0;
    check(acc ? "busy_after_start" : "busy_after_ignored_start", 32'(busy), 1);
  endtask

  task automatic wait_done(input int max_cyc);
    int d0 = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == d0; i++) tick();
    check("done_timeout", 32'(done_cnt > d0), 1);
    tick();
    tick();
    check("done_once", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic wait_deq(input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && deq_cnt < target; i++) tick();
    check("deq_timeout", 32'(deq_cnt >= target), 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : watchdog
    #600000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int stop_cyc;
    int n;
    int c;
    rst_n = 1'b0; start = 1'b0; count = '0; stop = 1'b0; m_ready = 1'b0;
    ticks(3);
    // Reset values
    check("rst_deq", 32'(deq), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_key", 32'(m_key), 0);
    check("rst_m_val", 32'(m_val), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_order_err", 32'(order_err), 0);
    rst_n = 1'b1;
    ticks(2);

    // Counted drain of four entries, sorted delivery, full throughput
    got_keys.delete(); got_vals.delete(); acc_cyc.delete();
    enq(8'd8, 8'd14); enq(8'd11, 8'd11); enq(8'd9, 8'd9); enq(8'd10, 8'd10);
    m_ready = 1'b1;
    do_start(4);
    wait_done(50);
    check("t1_beats", 32'(got_keys.size()), 4);
    if (got_keys.size() == 4) begin
      check("t1_k0", 32'(got_keys[0]), 8);  check("t1_v0", 32'(got_vals[0]), 14);
      check("t1_k1", 32'(got_keys[1]), 9);  check("t1_v1", 32'(got_vals[1]), 9);
      check("t1_k2", 32'(got_keys[2]), 10); check("t1_v2", 32'(got_vals[2]), 10);
      check("t1_k3", 32'(got_keys[3]), 11); check("t1_v3", 32'(got_vals[3]), 11);
      check("t1_back_to_back", 32'(acc_cyc[3] - acc_cyc[0]), 3);
    end
    check("t1_order_err", 32'(order_err), 0);

    // Back-pressure: only two entries fit, rest follow when ready rises
    d0 = deq_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) enq(8'($urandom_range(0, 255)), 8'($urandom));
    do_start(0);
    ticks(8);
    check("t2_deq_stalled", 32'(deq_cnt - d0), 2);
    check("t2_m_valid_held", 32'(m_valid), 1);
    do_start(1);
    acc_cyc.delete();
    m_ready = 1'b1;
    ticks(6);
    check("t2_deq_all", 32'(deq_cnt - d0), 4);
    check("t2_busy", 32'(busy), 1);
    check("t2_beats", 32'(acc_cyc.size()), 4);
    if (acc_cyc.size() == 4) check("t2_back_to_back", 32'(acc_cyc[3] - acc_cyc[0]), 3);
    // The ignored start must not have capped the continuous drain
    enq(8'd77, 8'd1); enq(8'd66, 8'd2);
    ticks(6);
    check("t2_still_continuous", 32'(deq_cnt - d0), 6);
    tick(); stop = 1'b1; tick(); stop = 1'b0;
    wait_done(20);

    // Counted drain that starts on an empty PQ
    d0 = deq_cnt;
    got_keys.delete();
    do_start(3);
    ticks(5);
    check("t3_no_deq_empty", 32'(deq_cnt - d0), 0);
    check("t3_busy_waiting", 32'(busy), 1);
    enq(8'd15, 8'd5);
    ticks(5);
    check("t3_one_deq", 32'(deq_cnt - d0), 1);
    check("t3_key15", 32'(got_keys.size() == 1 && got_keys[0] == 8'd15), 1);
    check("t3_still_busy", 32'(busy), 1);
    enq(8'd3, 8'd4); enq(8'd40, 8'd6);
    wait_done(30);
    check("t3_deq_total", 32'(deq_cnt - d0), 3);

    // stop coincides with the deq of key 12
    d0 = deq_cnt;
    got_keys.delete();
    do_start(0);
    ticks(2);
    tick();
    enq(8'd12, 8'd7);
    stop = 1'b1;
    stop_cyc = cyc;
    tick();
    stop = 1'b0;
    check("t4_deq_with_stop", 32'(last_deq_cyc), 32'(stop_cyc));
    wait_done(20);
    check("t4_key12", 32'(got_keys.size() == 1 && got_keys[0] == 8'd12), 1);
    enq(8'd200, 8'd1);
    ticks(5);
    check("t4_no_deq_after", 32'(deq_cnt - d0), 1);
    do_start(1);
    wait_done(20);
    check("t4_leftover_drained", 32'(deq_cnt - d0), 2);

    // Out-of-order PQ: 10 then 9
    faulty = 1'b1;
    enq(8'd10, 8'd1); enq(8'd9, 8'd2);
    tick();
    faulty = 1'b0;
    do_start(2);
    wait_done(20);
    check("t5_order_err", 32'(order_err), 32'(CHK));
    ticks(4);
    check("t5_order_err_sticky", 32'(order_err), 32'(CHK));
    enq(8'd50, 8'd3);
    do_start(1);
    check("t5_cleared_by_start", 32'(order_err), 0);
    wait_done(20);
    check("t5_single_not_flagged", 32'(order_err), 0);

    // Reset with two entries waiting in the FIFO
    d0 = deq_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) enq(8'($urandom_range(0, 255)), 8'($urandom));
    do_start(0);
    wait_deq(d0 + 2, 20);
    ticks(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_deq", 32'(deq), 0);
    check("t6_rst_m_valid", 32'(m_valid), 0);
    check("t6_rst_m_key", 32'(m_key), 0);
    check("t6_rst_m_val", 32'(m_val), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_order_err", 32'(order_err), 0);
    ticks(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    check("t6_pq_left", 32'(pq.size()), 2);
    do_start(2);
    wait_done(20);
    check("t6_deq_after_rst", 32'(deq_cnt - d0), 4);

    // Randomized drains with random back-pressure
    rand_ready = 1'b1;
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) enq(8'($urandom_range(0, 254)), 8'($urandom));
      tick();
      if (it % 4 == 0) begin
        do_start(0);
        enq(8'hff, 8'($urandom));
        for (int i = 0; i < 300 && pq.size() != 0; i++) tick();
        check("rnd_pq_drained", 32'(pq.size()), 0);
        stop = 1'b1; tick(); stop = 1'b0;
      end else begin
        c = $urandom_range(1, pq.size());
        d0 = deq_cnt;
        do_start(c);
        wait_done(300);
        check("rnd_count", 32'(deq_cnt - d0), 32'(c));
        continue;
      end
      wait_done(300);
      check("rnd_order_err", 32'(order_err), 0);
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    ticks(4);
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pq_drain
